// File: rtl/operand_fetch_stage_pkg.sv
// Shared decode constants, pipeline bundle types and the operand forwarding helper
// used by the operand fetch stage.
package cpu_pkg;

  localparam int PKG_XLEN   = 32;
  localparam int PKG_REG_AW = 5;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] instr;
  } fetch_bundle_t;

  typedef struct packed {
    logic [PKG_XLEN-1:0]   pc;
    logic [6:0]            opcode;
    logic [PKG_REG_AW-1:0] rd;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [PKG_REG_AW-1:0] rs1_idx;
    logic [PKG_REG_AW-1:0] rs2_idx;
    logic [PKG_XLEN-1:0]   rs1_val;
    logic [PKG_XLEN-1:0]   rs2_val;
    logic [PKG_XLEN-1:0]   imm;
  } decoded_t;

  // x0 reads as zero; otherwise a same-cycle writeback wins over the stale file read.
  function automatic logic [PKG_XLEN-1:0] select_operand(
    input logic [PKG_REG_AW-1:0] idx,
    input logic [PKG_XLEN-1:0]   rf_data,
    input logic                  wb_we,
    input logic [PKG_REG_AW-1:0] wb_wa,
    input logic [PKG_XLEN-1:0]   wb_wd
  );
    logic [PKG_XLEN-1:0] val;
    val = rf_data;
    if (idx == '0)
      val = '0;
    else if (wb_we && (wb_wa == idx))
      val = wb_wd;
    return val;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_imm_gen.sv
// Combinational immediate generator: sign-extended I/S/B/U/J immediates selected by opcode.
// Only instantiated when IMM_DECODE_EN is defined.
module imm_gen
  import cpu_pkg::*;
(
  input  logic [PKG_XLEN-1:0] instr,
  output logic [PKG_XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_IMM, LOAD, JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      LUI, AUIPC:
        imm = {instr[31:12], 12'b0};
      JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage feeding execute through a single-entry output register.
// Define IMM_DECODE_EN to register a decoded immediate on out_imm; otherwise out_imm is 0.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [XLEN-1:0]   wb_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [6:0]        out_opcode,
  output logic [REG_AW-1:0] out_rd,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [REG_AW-1:0] out_rs1_idx,
  output logic [REG_AW-1:0] out_rs2_idx,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [XLEN-1:0]   out_imm
);

  fetch_bundle_t bundle;
  decoded_t      captured;
  decoded_t      held;
  logic          valid_q;
  logic          accept;
  logic          stalled;
  logic [XLEN-1:0] imm_next;

  assign bundle = '{pc: in_pc, instr: in_instr};

  assign ra1 = bundle.instr[19:15];
  assign ra2 = bundle.instr[24:20];

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign stalled  = valid_q && !out_ready;

`ifdef IMM_DECODE_EN
  imm_gen u_imm_gen (
    .instr (bundle.instr),
    .imm   (imm_next)
  );
`else
  assign imm_next = '0;
`endif

  always_comb begin
    captured         = '0;
    captured.pc      = bundle.pc;
    captured.opcode  = bundle.instr[6:0];
    captured.rd      = bundle.instr[11:7];
    captured.funct3  = bundle.instr[14:12];
    captured.funct7  = bundle.instr[31:25];
    captured.rs1_idx = bundle.instr[19:15];
    captured.rs2_idx = bundle.instr[24:20];
    captured.rs1_val = select_operand(bundle.instr[19:15], rd1, wb_we, wb_wa, wb_wd);
    captured.rs2_val = select_operand(bundle.instr[24:20], rd2, wb_we, wb_wa, wb_wd);
    captured.imm     = imm_next;
  end

  // A held entry snoops writebacks so its operands stay current for however long execute stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      held    <= '0;
    end else begin
      if (flush)
        valid_q <= 1'b0;
      else if (accept)
        valid_q <= 1'b1;
      else if (out_ready)
        valid_q <= 1'b0;

      if (accept) begin
        held <= captured;
      end else if (stalled) begin
        if (wb_we && (wb_wa != '0) && (wb_wa == held.rs1_idx))
          held.rs1_val <= wb_wd;
        if (wb_we && (wb_wa != '0) && (wb_wa == held.rs2_idx))
          held.rs2_val <= wb_wd;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = held.pc;
  assign out_opcode  = held.opcode;
  assign out_rd      = held.rd;
  assign out_funct3  = held.funct3;
  assign out_funct7  = held.funct7;
  assign out_rs1_idx = held.rs1_idx;
  assign out_rs2_idx = held.rs2_idx;
  assign out_rs1_val = held.rs1_val;
  assign out_rs2_val = held.rs2_val;
  assign out_imm     = held.imm;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: a transaction-level model compared every
// cycle, plus literal expectations for the forwarding, snoop, x0, flush and immediate cases.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1 = '0;
  logic [31:0] rd2 = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_wa = '0;
  logic [31:0] wb_wd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rs1_idx, out_rs2_idx;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1_idx(out_rs1_idx), .out_rs2_idx(out_rs2_idx),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: the held entry is remembered as the raw instruction word plus operands.
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_rs1 = '0;
  logic [31:0] m_rs2 = '0;
  logic [31:0] m_imm = '0;

  function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] file_val);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_wa != 5'd0 && wb_wa == idx) return wb_wd;
    return file_val;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic signed [31:0] s;
    logic signed [12:0] b;
    logic signed [20:0] j;
    s = w;
`ifdef IMM_DECODE_EN
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return s >>> 20;
      7'b0100011: return ((s >>> 20) & ~32'h1F) | {27'd0, w[11:7]};
      7'b1100011: begin
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        s = b;
        return s;
      end
      7'b0110111, 7'b0010111: return w & 32'hFFFF_F000;
      7'b1101111: begin
        j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        s = j;
        return s;
      end
      default: return 32'd0;
    endcase
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge clk) begin
    bit take, hold;
    if (!rst) begin
      m_valid = 1'b0;
      m_instr = '0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
    end else begin
      take = in_valid && (!m_valid || out_ready) && !flush;
      hold = m_valid && !out_ready;
      if (take) begin
        m_instr = in_instr;
        m_pc    = in_pc;
        m_rs1   = ref_operand(in_instr[19:15], rd1);
        m_rs2   = ref_operand(in_instr[24:20], rd2);
        m_imm   = ref_imm(in_instr);
      end else if (hold) begin
        if (wb_we && wb_wa != 5'd0 && wb_wa == m_instr[19:15]) m_rs1 = wb_wd;
        if (wb_we && wb_wa != 5'd0 && wb_wa == m_instr[24:20]) m_rs2 = wb_wd;
      end
      if (flush) m_valid = 1'b0;
      else if (take) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_output("out_valid", out_valid, m_valid);
      check_output("in_ready", in_ready, !m_valid || out_ready);
      check_output("ra1", ra1, in_instr[19:15]);
      check_output("ra2", ra2, in_instr[24:20]);
      check_output("out_pc", out_pc, m_pc);
      check_output("out_opcode", out_opcode, m_instr[6:0]);
      check_output("out_rd", out_rd, m_instr[11:7]);
      check_output("out_funct3", out_funct3, m_instr[14:12]);
      check_output("out_funct7", out_funct7, m_instr[31:25]);
      check_output("out_rs1_idx", out_rs1_idx, m_instr[19:15]);
      check_output("out_rs2_idx", out_rs2_idx, m_instr[24:20]);
      check_output("out_rs1_val", out_rs1_val, m_rs1);
      check_output("out_rs2_val", out_rs2_val, m_rs2);
      check_output("out_imm", out_imm, m_imm);
    end
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ordy, input logic fl);
    in_valid = v; in_instr = instr; in_pc = pc;
    rd1 = r1; rd2 = r2;
    wb_we = we; wb_wa = wa; wb_wd = wd;
    out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_instr [3];
  logic [31:0] imm_all_ones;
  logic [31:0] imm_jal;
  logic [31:0] imm_lui;

  initial begin
    b2b_instr[0] = 32'h0051_2423; // sw x5,8(x2)
    b2b_instr[1] = 32'h1234_50B7; // lui x1,0x12345
    b2b_instr[2] = 32'hFE00_0EE3; // beq x0,x0,-4
`ifdef IMM_DECODE_EN
    imm_all_ones = 32'hFFFF_FFFF;
    imm_jal      = 32'hFFFF_FFF8;
    imm_lui      = 32'h1234_5000;
`else
    imm_all_ones = 32'h0;
    imm_jal      = 32'h0;
    imm_lui      = 32'h0;
`endif

    rst = 1'b0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_out_valid", out_valid, 32'd0);
    check_output("reset_in_ready", in_ready, 32'd1);
    check_output("reset_rs1_val", out_rs1_val, 32'd0);
    rst = 1'b1;

    // add x3,x1,x2 with a same-cycle writeback to x1
    apply_stimulus(1, 32'h0020_81B3, 32'h100, 32'd5, 32'd7, 1, 5'd1, 32'h99, 0, 0);
    check_output("fwd_out_valid", out_valid, 32'd1);
    check_output("fwd_rs1_val", out_rs1_val, 32'h99);
    check_output("fwd_rs2_val", out_rs2_val, 32'd7);
    check_output("fwd_out_rd", out_rd, 32'd3);

    // add x5,x1,x4 replaces it, then stalls and snoops
    apply_stimulus(1, 32'h0040_82B3, 32'h104, 32'h11, 32'h22, 0, 5'd0, 32'h0, 1, 0);
    check_output("refill_pc", out_pc, 32'h104);
    apply_stimulus(1, 32'h00C5_8633, 32'h108, 32'h33, 32'h44, 1, 5'd4, 32'h1234, 0, 0);
    check_output("snoop_rs2_val", out_rs2_val, 32'h1234);
    check_output("snoop_rs1_hold", out_rs1_val, 32'h11);
    check_output("snoop_in_ready", in_ready, 32'd0);
    check_output("snoop_pc_hold", out_pc, 32'h104);
    apply_stimulus(1, 32'h00C5_8633, 32'h108, 32'h33, 32'h44, 1, 5'd1, 32'hABCD, 0, 0);
    check_output("snoop_rs1_val", out_rs1_val, 32'hABCD);

    // reset while stalled
    rst = 1'b0;
    apply_stimulus(1, 32'h00C5_8633, 32'h108, 32'h33, 32'h44, 0, 5'd0, 32'h0, 0, 0);
    check_output("midreset_out_valid", out_valid, 32'd0);
    check_output("midreset_rs1_val", out_rs1_val, 32'd0);
    check_output("midreset_in_ready", in_ready, 32'd1);
    rst = 1'b1;

    // add x6,x0,x2 with a write to x0 that must be ignored
    apply_stimulus(1, 32'h0020_0333, 32'h200, 32'hFFFF, 32'h55, 1, 5'd0, 32'd5, 1, 0);
    check_output("x0_rs1_val", out_rs1_val, 32'd0);
    check_output("x0_rs2_val", out_rs2_val, 32'h55);

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, b2b_instr[i], 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 5'd0, 32'h0, 1, 0);
      check_output("b2b_out_valid", out_valid, 32'd1);
      check_output("b2b_out_pc", out_pc, 32'h300 + 32'(4 * i));
    end
    check_output("lui_imm", out_imm, imm_lui);

    apply_stimulus(1, 32'hFF9F_F0EF, 32'h400, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, 1);
    check_output("flush_out_valid", out_valid, 32'd0);
    check_output("flush_pc_hold", out_pc, 32'h308);

    // addi x1,x0,-1
    apply_stimulus(1, 32'hFFF0_0093, 32'h500, 32'h77, 32'h88, 0, 5'd0, 32'h0, 1, 0);
    check_output("addi_out_valid", out_valid, 32'd1);
    check_output("addi_imm", out_imm, imm_all_ones);
    check_output("addi_rs1_val", out_rs1_val, 32'd0);

    // jal x1,-8
    apply_stimulus(1, 32'hFF9F_F0EF, 32'h504, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, 0);
    check_output("jal_imm", out_imm, imm_jal);

    apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, 0);
    check_output("drain_out_valid", out_valid, 32'd0);
    apply_stimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
